scan_mux: RTL and testbench
===========================

# scan_mux

Parametrised, registered N-channel word selector with a built-in auto-scan sequencer. It supersedes the fixed 8-way 4-bit combinational selector. It adds configurable width and channel count, a registered output, and a timed round-robin scan mode for multiplexed displays and time-shared datapaths. It sits between the channel sources (registers, BCD digits) and a single shared consumer (display driver, ALU operand bus).

## Interface
- WIDTH, 4, bits per channel word
- CHANNELS, 8, number of input channels (2..256)
- SEL_W, $clog2(CHANNELS), select/channel index width
- DWELL, 4, clock cycles each channel is held in scan mode (>=1)

- Clock  in  1  single system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Mode  in  1  0 = manual (S selects), 1 = auto-scan
- S  in  SEL_W  manual select / scan load index
- Load  in  1  scan mode: jump to channel S
- Hold  in  1  scan mode: freeze channel and dwell counter
- W  in  CHANNELS*WIDTH  flattened inputs; channel k = W[k*WIDTH +: WIDTH]
- F  out  WIDTH  registered selected word
- Ch  out  SEL_W  channel index F was taken from
- Valid  out  1  F holds an in-range channel's data
- Wrap  out  1  one-cycle pulse when scan wraps CHANNELS-1 -> 0

## Operation
- Internal state: Ch register, dwell counter Cnt (0..DWELL-1), F, Valid, Wrap.
- The next channel Ch_n is computed each cycle. At the edge: Ch <= Ch_n, then F <= W[Ch_n] sampled at that edge. F and Ch are therefore always consistent.
- Manual mode (Mode=0):
  - Ch_n = S; Cnt <= 0; Wrap <= 0.
  - If S >= CHANNELS: F <= 0, Valid <= 0, Ch <= S.
  - Otherwise Valid <= 1.
- Scan mode (Mode=1), priority Load > Hold > advance:
  - Load=1: Ch_n = S, Cnt <= 0. An out-of-range S is clamped to 0.
  - Hold=1: Ch_n = Ch, Cnt unchanged. F still tracks W[Ch] every cycle.
  - Otherwise, if Cnt == DWELL-1: Cnt <= 0 and Ch_n = Ch+1, or 0 if Ch == CHANNELS-1. Wrap <= 1 only on that wrap.
  - Otherwise Cnt <= Cnt+1 and Ch_n = Ch.
  - Valid <= 1 always in scan mode.
- Mode 0->1 transition: scan starts at the current Ch with Cnt = 0. If Ch is out of range, it is replaced by 0 on the first scan edge.
- Mode 1->0 transition: the next edge takes S. Cnt clears.
- Wrap is 0 on every edge where it is not explicitly set, including Load and Hold edges.
- Non-power-of-two CHANNELS: indices CHANNELS..2^SEL_W-1 are never produced by scan.

## Timing
- Reset is checked at the rising edge, and Reset=1 overrides all inputs. It yields F=0, Ch=0, Cnt=0, Valid=0, Wrap=0.
- Reset asserted mid-scan or mid-dwell aborts immediately. No partial state survives.
- First valid output: the first edge with Reset=0. Valid rises there.
- Latency: 1 cycle from S/W/Mode/Load change to F/Ch/Valid.
- Scan period: each channel is shown for exactly DWELL cycles (Hold cycles excluded). A full rotation is CHANNELS*DWELL cycles.
- DWELL=1: the channel advances on every non-Hold edge.
- Wrap coincides with the edge where Ch becomes 0 via advance. It is high for exactly one cycle.
- Load and Hold together: Load wins, and Cnt resets.
- Inputs are assumed synchronous to Clock. No internal synchronisers.

## Test plan
- Reset then manual: WIDTH=4, CHANNELS=8, W_k=k+3, Reset 2 cycles, Mode=0, S=5 -> F=0/Valid=0 during reset; one edge after release F=8, Ch=5, Valid=1.
- Scan rotation: DWELL=4, Mode=1 from Ch=0 -> Ch steps 0..7, each held 4 cycles. Wrap pulses once at cycle 32 as Ch returns to 0. F=W[Ch] every cycle.
- Hold/Load: during scan at Ch=2, Cnt=1, assert Hold 5 cycles while changing W2 to 0xA -> Ch stays 2 and F=0xA the next cycle. Then Load=1, Hold=1, S=6 -> Ch=6, Cnt=0, Wrap=0.
- Out-of-range: CHANNELS=6 (SEL_W=3), manual S=7 -> F=0, Valid=0. Switch to scan -> Ch=0 and Valid=1 on the next edge. Scan never emits 6 or 7.
- Reset mid-operation: in scan at Ch=4, Cnt=3, assert Reset one cycle -> F=0, Ch=0, Valid=0, Wrap=0. Scan restarts at Ch=0, and channel 0 is held the full DWELL cycles.
- Parametrisation: WIDTH=8, CHANNELS=3, DWELL=1 -> Ch sequence 0,1,2,0 with Wrap on every third edge; F matches W[Ch] bit-exactly.

Source files
------------

// File: rtl/scan_mux.sv
// scan_mux: registered N-channel word selector with a timed round-robin
// auto-scan sequencer. F and Ch are updated on the same edge, so the
// word shown is always the word of the channel reported.
module scan_mux #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = $clog2(CHANNELS),
  parameter int unsigned DWELL    = 4
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Mode,
  input  logic [SEL_W-1:0]          S,
  input  logic                      Load,
  input  logic                      Hold,
  input  logic [CHANNELS*WIDTH-1:0] W,
  output logic [WIDTH-1:0]          F,
  output logic [SEL_W-1:0]          Ch,
  output logic                      Valid,
  output logic                      Wrap
);

  // Dwell counter needs at least one bit even when DWELL is 1.
  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  logic [SEL_W-1:0] ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             s_in_range;
  logic             ch_in_range;

  assign s_in_range  = (32'(S) < CHANNELS);
  assign ch_in_range = (32'(ch_q) < CHANNELS);

  // Next channel / dwell / flags; priority is Mode, then Load > Hold > advance.
  always_comb begin
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    valid_d = 1'b1;
    wrap_d  = 1'b0;
    if (!Mode) begin
      ch_d    = S;
      cnt_d   = '0;
      valid_d = s_in_range;
    end else if (Load) begin
      ch_d  = s_in_range ? S : '0;
      cnt_d = '0;
    end else if (!ch_in_range) begin
      // Entering scan from an out-of-range manual select restarts at channel 0.
      ch_d  = '0;
      cnt_d = '0;
    end else if (Hold) begin
      ch_d  = ch_q;
      cnt_d = cnt_q;
    end else if (cnt_q == LAST_CNT) begin
      cnt_d = '0;
      if (ch_q == LAST_CH) begin
        ch_d   = '0;
        wrap_d = 1'b1;
      end else begin
        ch_d = ch_q + SEL_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Word select for the next channel; zero whenever that channel is out of range.
  always_comb begin
    f_d = '0;
    if (valid_d) begin
      for (int k = 0; k < int'(CHANNELS); k++) begin
        if (ch_d == SEL_W'(k)) f_d = W[k*WIDTH +: WIDTH];
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ch_q    <= '0;
      cnt_q   <= '0;
      f_q     <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign F     = f_q;
  assign Ch    = ch_q;
  assign Valid = valid_q;
  assign Wrap  = wrap_q;

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: three parametrisations, a behavioural
// reference model feeding a scoreboard, plus fixed-value checks.
module tb_scan_mux;

  typedef struct {
    logic [7:0] f;
    int         ch;
    bit         valid;
    bit         wrap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // A: WIDTH=4, CHANNELS=8, DWELL=4
  logic        a_reset = 1'b1, a_mode = 1'b0, a_load = 1'b0, a_hold = 1'b0;
  logic [2:0]  a_s = '0;
  logic [31:0] a_w = '0;
  logic [3:0]  a_f;
  logic [2:0]  a_ch;
  logic        a_valid, a_wrap;
  int          ma_ch = 0, ma_cnt = 0;

  // B: WIDTH=4, CHANNELS=6, DWELL=4
  logic        b_reset = 1'b1, b_mode = 1'b0, b_load = 1'b0, b_hold = 1'b0;
  logic [2:0]  b_s = '0;
  logic [23:0] b_w = '0;
  logic [3:0]  b_f;
  logic [2:0]  b_ch;
  logic        b_valid, b_wrap;
  int          mb_ch = 0, mb_cnt = 0;

  // C: WIDTH=8, CHANNELS=3, DWELL=1
  logic        c_reset = 1'b1, c_mode = 1'b0, c_load = 1'b0, c_hold = 1'b0;
  logic [1:0]  c_s = '0;
  logic [23:0] c_w = '0;
  logic [7:0]  c_f;
  logic [1:0]  c_ch;
  logic        c_valid, c_wrap;
  int          mc_ch = 0, mc_cnt = 0;

  scan_mux #(.WIDTH(4), .CHANNELS(8), .DWELL(4)) u_a (
    .Clock(clk), .Reset(a_reset), .Mode(a_mode), .S(a_s), .Load(a_load), .Hold(a_hold),
    .W(a_w), .F(a_f), .Ch(a_ch), .Valid(a_valid), .Wrap(a_wrap)
  );
  scan_mux #(.WIDTH(4), .CHANNELS(6), .DWELL(4)) u_b (
    .Clock(clk), .Reset(b_reset), .Mode(b_mode), .S(b_s), .Load(b_load), .Hold(b_hold),
    .W(b_w), .F(b_f), .Ch(b_ch), .Valid(b_valid), .Wrap(b_wrap)
  );
  scan_mux #(.WIDTH(8), .CHANNELS(3), .DWELL(1)) u_c (
    .Clock(clk), .Reset(c_reset), .Mode(c_mode), .S(c_s), .Load(c_load), .Hold(c_hold),
    .W(c_w), .F(c_f), .Ch(c_ch), .Valid(c_valid), .Wrap(c_wrap)
  );

  // Reference model of one clock edge.
  function automatic void model(input int channels, input int dwell, input logic reset,
                                input logic mode, input logic load, input logic hold,
                                input int s, inout int ch, inout int cnt,
                                output bit valid, output bit wrap);
    valid = 1'b1;
    wrap  = 1'b0;
    if (reset) begin
      ch = 0; cnt = 0; valid = 1'b0;
    end else if (!mode) begin
      ch = s; cnt = 0; valid = (s < channels);
    end else if (load) begin
      ch = (s < channels) ? s : 0; cnt = 0;
    end else if (ch >= channels) begin
      ch = 0; cnt = 0;
    end else if (hold) begin
      // frozen
    end else if (cnt == dwell - 1) begin
      cnt = 0;
      if (ch == channels - 1) begin ch = 0; wrap = 1'b1; end
      else ch = ch + 1;
    end else begin
      cnt = cnt + 1;
    end
  endfunction

  task automatic step_a();
    exp_t e; bit v, w;
    model(8, 4, a_reset, a_mode, a_load, a_hold, int'(a_s), ma_ch, ma_cnt, v, w);
    e.ch = ma_ch; e.valid = v; e.wrap = w;
    e.f = v ? 8'((a_w >> (ma_ch * 4)) & 32'hF) : 8'h0;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic step_b();
    exp_t e; bit v, w;
    model(6, 4, b_reset, b_mode, b_load, b_hold, int'(b_s), mb_ch, mb_cnt, v, w);
    e.ch = mb_ch; e.valid = v; e.wrap = w;
    e.f = v ? 8'((b_w >> (mb_ch * 4)) & 24'hF) : 8'h0;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic step_c();
    exp_t e; bit v, w;
    model(3, 1, c_reset, c_mode, c_load, c_hold, int'(c_s), mc_ch, mc_cnt, v, w);
    e.ch = mc_ch; e.valid = v; e.wrap = w;
    e.f = v ? 8'((c_w >> (mc_ch * 8)) & 24'hFF) : 8'h0;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] ramp_a();
    logic [31:0] w;
    for (int k = 0; k < 8; k++) w[k*4 +: 4] = 4'(k + 3);
    return w;
  endfunction

  task automatic test_reset();
    exp_t e;
    a_reset = 1'b1; a_mode = 1'b0; a_s = 3'd5; a_load = 1'b0; a_hold = 1'b0; a_w = ramp_a();
    for (int i = 0; i < 2; i++) begin
      step_a(); e = sb.pop_front();
      n_checks++;
      if (a_f !== e.f[3:0] || a_ch !== e.ch[2:0] || a_valid !== e.valid || a_wrap !== e.wrap) begin
        n_fail++;
        $display("FAIL reset_sb: got f=%h ch=%0d v=%b w=%b expected f=%h ch=%0d v=%b w=%b",
                 a_f, a_ch, a_valid, a_wrap, e.f[3:0], e.ch, e.valid, e.wrap);
      end
      n_checks++;
      if (a_f !== 4'h0 || a_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: got f=%h v=%b expected f=0 v=0", a_f, a_valid);
      end
    end
    a_reset = 1'b0;
    step_a(); e = sb.pop_front();
    n_checks++;
    if (a_f !== e.f[3:0] || a_ch !== e.ch[2:0] || a_valid !== e.valid || a_wrap !== e.wrap) begin
      n_fail++;
      $display("FAIL reset_release_sb: got f=%h ch=%0d v=%b expected f=%h ch=%0d v=%b",
               a_f, a_ch, a_valid, e.f[3:0], e.ch, e.valid);
    end
    n_checks++;
    if (a_f !== 4'h8 || a_ch !== 3'd5 || a_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got f=%h ch=%0d v=%b expected f=8 ch=5 v=1",
               a_f, a_ch, a_valid);
    end
  endtask

  task automatic test_scan_rotation();
    exp_t e;
    int wraps = 0, wrap_at = -1;
    a_mode = 1'b0; a_s = 3'd0;
    step_a(); void'(sb.pop_front());
    a_mode = 1'b1;
    for (int i = 0; i < 32; i++) begin
      a_w = $urandom;
      step_a(); e = sb.pop_front();
      if (a_wrap === 1'b1) begin wraps++; wrap_at = i; end
      n_checks++;
      if (a_f !== e.f[3:0] || a_ch !== e.ch[2:0] || a_valid !== e.valid || a_wrap !== e.wrap) begin
        n_fail++;
        $display("FAIL scan_sb cyc %0d: got f=%h ch=%0d v=%b w=%b expected f=%h ch=%0d v=%b w=%b",
                 i, a_f, a_ch, a_valid, a_wrap, e.f[3:0], e.ch, e.valid, e.wrap);
      end
      n_checks++;
      if (a_ch !== 3'(((i + 1) / 4) % 8)) begin
        n_fail++;
        $display("FAIL scan_seq cyc %0d: got ch=%0d expected ch=%0d", i, a_ch, ((i + 1) / 4) % 8);
      end
    end
    n_checks++;
    if (wraps != 1 || wrap_at != 31) begin
      n_fail++;
      $display("FAIL scan_wrap: got %0d wraps last at %0d expected 1 wrap at 31", wraps, wrap_at);
    end
  endtask

  task automatic test_hold_load();
    exp_t e;
    a_w = ramp_a();
    for (int i = 0; i < 9; i++) begin
      step_a(); void'(sb.pop_front());
    end
    n_checks++;
    if (a_ch !== 3'd2) begin
      n_fail++;
      $display("FAIL hold_setup: got ch=%0d expected ch=2", a_ch);
    end
    a_hold = 1'b1; a_w[8 +: 4] = 4'hA;
    for (int i = 0; i < 5; i++) begin
      step_a(); e = sb.pop_front();
      n_checks++;
      if (a_f !== e.f[3:0] || a_ch !== e.ch[2:0] || a_wrap !== e.wrap) begin
        n_fail++;
        $display("FAIL hold_sb cyc %0d: got f=%h ch=%0d expected f=%h ch=%0d",
                 i, a_f, a_ch, e.f[3:0], e.ch);
      end
      n_checks++;
      if (a_ch !== 3'd2 || a_f !== 4'hA) begin
        n_fail++;
        $display("FAIL hold_freeze cyc %0d: got f=%h ch=%0d expected f=a ch=2", i, a_f, a_ch);
      end
    end
    a_load = 1'b1; a_s = 3'd6;
    step_a(); void'(sb.pop_front());
    n_checks++;
    if (a_ch !== 3'd6 || a_wrap !== 1'b0 || a_f !== 4'h9) begin
      n_fail++;
      $display("FAIL load_hold: got ch=%0d w=%b f=%h expected ch=6 w=0 f=9", a_ch, a_wrap, a_f);
    end
    a_load = 1'b0; a_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step_a(); void'(sb.pop_front());
      n_checks++;
      if (a_ch !== ((i < 3) ? 3'd6 : 3'd7)) begin
        n_fail++;
        $display("FAIL load_dwell cyc %0d: got ch=%0d expected ch=%0d", i, a_ch, (i < 3) ? 6 : 7);
      end
    end
    // Hold across the wrap point must not pulse Wrap.
    for (int i = 0; i < 6; i++) begin
      a_hold = (i == 3 || i == 4);
      step_a(); e = sb.pop_front();
      n_checks++;
      if (a_ch !== e.ch[2:0] || a_wrap !== e.wrap || a_f !== e.f[3:0]) begin
        n_fail++;
        $display("FAIL hold_wrap cyc %0d: got ch=%0d w=%b expected ch=%0d w=%b",
                 i, a_ch, a_wrap, e.ch, e.wrap);
      end
    end
    a_hold = 1'b0;
  endtask

  task automatic test_reset_mid();
    a_mode = 1'b0; a_s = 3'd4; a_w = ramp_a();
    step_a(); void'(sb.pop_front());
    a_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin step_a(); void'(sb.pop_front()); end
    a_reset = 1'b1;
    step_a(); void'(sb.pop_front());
    n_checks++;
    if (a_f !== 4'h0 || a_ch !== 3'd0 || a_valid !== 1'b0 || a_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got f=%h ch=%0d v=%b w=%b expected 0 0 0 0",
               a_f, a_ch, a_valid, a_wrap);
    end
    a_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step_a(); void'(sb.pop_front());
      n_checks++;
      if (a_ch !== ((i < 3) ? 3'd0 : 3'd1) || a_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_restart cyc %0d: got ch=%0d v=%b expected ch=%0d v=1",
                 i, a_ch, a_valid, (i < 3) ? 0 : 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 200; i++) begin
      a_mode = ($urandom_range(0, 3) != 0);
      a_load = ($urandom_range(0, 7) == 0);
      a_hold = ($urandom_range(0, 5) == 0);
      a_s    = 3'($urandom);
      a_w    = $urandom;
      a_reset = ($urandom_range(0, 63) == 0);
      step_a(); e = sb.pop_front();
      n_checks++;
      if (a_f !== e.f[3:0] || a_ch !== e.ch[2:0] || a_valid !== e.valid || a_wrap !== e.wrap) begin
        n_fail++;
        $display("FAIL b2b cyc %0d: got f=%h ch=%0d v=%b w=%b expected f=%h ch=%0d v=%b w=%b",
                 i, a_f, a_ch, a_valid, a_wrap, e.f[3:0], e.ch, e.valid, e.wrap);
      end
    end
    a_reset = 1'b0;
  endtask

  task automatic test_out_of_range();
    exp_t e;
    for (int k = 0; k < 6; k++) b_w[k*4 +: 4] = 4'(k + 3);
    b_reset = 1'b1;
    step_b(); void'(sb.pop_front());
    b_reset = 1'b0; b_mode = 1'b0; b_s = 3'd7;
    step_b(); e = sb.pop_front();
    n_checks++;
    if (b_f !== 4'h0 || b_valid !== 1'b0 || b_ch !== 3'd7 || b_ch !== e.ch[2:0]) begin
      n_fail++;
      $display("FAIL oor_manual: got f=%h v=%b ch=%0d expected f=0 v=0 ch=7", b_f, b_valid, b_ch);
    end
    b_mode = 1'b1;
    step_b(); void'(sb.pop_front());
    n_checks++;
    if (b_ch !== 3'd0 || b_valid !== 1'b1 || b_f !== 4'h3) begin
      n_fail++;
      $display("FAIL oor_to_scan: got ch=%0d v=%b f=%h expected ch=0 v=1 f=3", b_ch, b_valid, b_f);
    end
    for (int i = 0; i < 30; i++) begin
      b_w = 24'($urandom);
      step_b(); e = sb.pop_front();
      n_checks++;
      if (b_ch > 3'd5 || b_ch !== e.ch[2:0] || b_f !== e.f[3:0] || b_wrap !== e.wrap) begin
        n_fail++;
        $display("FAIL oor_scan cyc %0d: got ch=%0d f=%h w=%b expected ch=%0d f=%h w=%b",
                 i, b_ch, b_f, b_wrap, e.ch, e.f[3:0], e.wrap);
      end
    end
    b_load = 1'b1; b_s = 3'd7;
    step_b(); void'(sb.pop_front());
    n_checks++;
    if (b_ch !== 3'd0 || b_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_load_clamp: got ch=%0d v=%b expected ch=0 v=1", b_ch, b_valid);
    end
    b_load = 1'b0; b_mode = 1'b0; b_s = 3'd3;
    step_b(); void'(sb.pop_front());
    n_checks++;
    if (b_ch !== 3'd3 || b_valid !== 1'b1 || b_f !== b_w[15:12]) begin
      n_fail++;
      $display("FAIL scan_to_manual: got ch=%0d v=%b f=%h expected ch=3 v=1 f=%h",
               b_ch, b_valid, b_f, b_w[15:12]);
    end
  endtask

  task automatic test_params();
    exp_t e;
    logic [7:0] words [3];
    words[0] = 8'h81; words[1] = 8'h5A; words[2] = 8'hC3;
    c_w = {words[2], words[1], words[0]};
    c_reset = 1'b1; c_mode = 1'b1;
    step_c(); void'(sb.pop_front());
    c_reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step_c(); e = sb.pop_front();
      n_checks++;
      if (c_ch !== 2'((i + 1) % 3) || c_wrap !== ((i + 1) % 3 == 0) ||
          c_f !== words[(i + 1) % 3] || c_valid !== 1'b1 || c_f !== e.f) begin
        n_fail++;
        $display("FAIL params cyc %0d: got ch=%0d w=%b f=%h v=%b expected ch=%0d w=%b f=%h v=1",
                 i, c_ch, c_wrap, c_f, c_valid, (i + 1) % 3, ((i + 1) % 3 == 0),
                 words[(i + 1) % 3]);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_scan_rotation();
    test_hold_load();
    test_reset_mid();
    test_back_to_back();
    test_out_of_range();
    test_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
